// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: 6502-side bus controller that sequences single-byte RAM/ROM
// accesses. A request is latched in IDLE. The controller then spends one WRITE
// cycle, or READ_LAT+1 READ cycles, before a single-cycle DONE/cpu_rdy pulse.
// cpu_addr[15] selects ROM (1) or RAM (0). Each region mirrors every 8 KiB.
// Optional feature: define MEMCTL_ROM_WP_EN to block ROM writes. A blocked
// write still completes normally and sets the sticky wp_err flag.
module mem_bus_ctrl #(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        ram_we,
    output logic        ram_oe,
    output logic        rom_we,
    output logic        rom_oe,
    output logic        wp_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT);

    state_e      state_q, state_d;
    logic        rom_q, rom_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wp_q, wp_d;
    logic [14:0] addr_dec;

    // Low address bits only; the region bit and mirror bits are dropped.
    assign addr_dec = 15'(cpu_addr[ADDR_W-1:0]);

    if (ADDR_W < 15) begin : g_mirror_bits
        logic unused_mirror_bits;
        assign unused_mirror_bits = ^cpu_addr[14:ADDR_W];
    end

    // State and latched transaction registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rom_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            wp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rom_q   <= rom_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
        end
    end

    // Next-state logic and per-state memory enables.
    always_comb begin
        state_d = state_q;
        rom_d   = rom_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        ram_we  = 1'b0;
        ram_oe  = 1'b0;
        rom_we  = 1'b0;
        rom_oe  = 1'b0;
        cpu_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = addr_dec;
                    rom_d   = cpu_addr[15];
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
                    state_d = cpu_we ? WRITE : READ;
                end
            end
            WRITE: begin
                ram_we = ~rom_q;
`ifdef MEMCTL_ROM_WP_EN
                if (rom_q) begin
                    wp_d = 1'b1;
                end
`else
                rom_we = rom_q;
`endif
                state_d = DONE;
            end
            READ: begin
                ram_oe = ~rom_q;
                rom_oe = rom_q;
                if (cnt_q == LAT_LAST) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                cpu_rdy = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef MEMCTL_ROM_WP_EN
    assign wp_err = wp_q;
`else
    assign wp_err = 1'b0;
    logic unused_wp;
    assign unused_wp = wp_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized self-checking bench for mem_bus_ctrl.
// The memory stage model returns inverted data until oe has been held for
// READ_LAT edges, so a capture that happens too early is visible.
// Expected read data comes from transaction-level RAM/ROM byte arrays.
module tb_mem_bus_ctrl;

    localparam int unsigned READ_LAT = 2;
`ifdef MEMCTL_ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        ram_we, ram_oe, rom_we, rom_oe, wp_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    logic [7:0] exp_ram [8192];
    logic [7:0] exp_rom [8192];
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_wp = 1'b0;

    mem_bus_ctrl #(.READ_LAT(READ_LAT), .ADDR_W(13)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rdy(cpu_rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ram_we(ram_we), .ram_oe(ram_oe),
        .rom_we(rom_we), .rom_oe(rom_oe), .wp_err(wp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [12:0] off, input logic rom);
        if (rom && off == 13'h1FFC) return 8'h00;
        return 8'(32'(off) * 7 + (rom ? 145 : 23));
    endfunction

    // Memory stage model.
    logic [7:0]  ram_mem [8192];
    logic [7:0]  rom_mem [8192];
    bit          mem_ready = 1'b0;
    int unsigned oe_cnt = 0;
    logic [7:0]  rd_v;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) begin
                ram_mem[i] <= init_byte(13'(i), 1'b0);
                rom_mem[i] <= init_byte(13'(i), 1'b1);
            end
            mem_ready <= 1'b1;
        end else begin
            if (ram_we) ram_mem[mem_addr[12:0]] <= mem_wdata;
            if (rom_we) rom_mem[mem_addr[12:0]] <= mem_wdata;
        end
        if (ram_oe || rom_oe) oe_cnt <= oe_cnt + 1;
        else oe_cnt <= 0;
    end

    always_comb begin
        rd_v = rom_oe ? rom_mem[mem_addr[12:0]] : ram_mem[mem_addr[12:0]];
        mem_rdata = (oe_cnt >= READ_LAT) ? rd_v : ~rd_v;
    end

    // One transaction. The task starts #1 after a posedge, with the DUT in
    // IDLE, and ends #1 into the IDLE cycle that follows DONE.
    task automatic run_txn(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                           input bit keep, output int unsigned rdy_cyc);
        logic        rom;
        logic [12:0] off;
        int unsigned lat;
        logic [3:0]  exp_en, got_en;
        logic [7:0]  exp_rd;
        rom = addr[15];
        off = 13'(addr % 16'd8192);
        lat = we ? 2 : READ_LAT + 2;
        exp_rd = rom ? exp_rom[off] : exp_ram[off];
        rdy_cyc = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
        if (!keep) cpu_req = 1'b0;
        for (int unsigned c = 1; c <= lat; c++) begin
            got_en = {ram_we, ram_oe, rom_we, rom_oe};
            if (c < lat) exp_en = {we && !rom, !we && !rom, we && rom && !WP, !we && rom};
            else exp_en = 4'b0000;
            if (c == lat && !we) exp_rdata = exp_rd;
            if (c == lat && we && rom && WP) exp_wp = 1'b1;
            n_cmp++;
            if (got_en !== exp_en) begin
                n_err++;
                $display("FAIL enables addr=%h cycle %0d: got %b expected %b", addr, c, got_en, exp_en);
            end
            n_cmp++;
            if (cpu_rdy !== (c == lat)) begin
                n_err++;
                $display("FAIL cpu_rdy addr=%h cycle %0d: got %b expected %b", addr, c, cpu_rdy, c == lat);
            end
            n_cmp++;
            if (mem_addr !== {2'b00, off}) begin
                n_err++;
                $display("FAIL mem_addr addr=%h cycle %0d: got %h expected %h", addr, c, mem_addr, {2'b00, off});
            end
            n_cmp++;
            if (cpu_rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL cpu_rdata addr=%h cycle %0d: got %h expected %h", addr, c, cpu_rdata, exp_rdata);
            end
            if (we && c < lat) begin
                n_cmp++;
                if (mem_wdata !== wd) begin
                    n_err++;
                    $display("FAIL mem_wdata addr=%h: got %h expected %h", addr, mem_wdata, wd);
                end
            end
            if (c == lat) begin
                rdy_cyc = cyc;
                n_cmp++;
                if (wp_err !== exp_wp) begin
                    n_err++;
                    $display("FAIL wp_err addr=%h: got %b expected %b", addr, wp_err, exp_wp);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (we) begin
            if (!rom) exp_ram[off] = wd;
            else if (!WP) exp_rom[off] = wd;
        end
        @(posedge clk); #1;
        got_en = {ram_we, ram_oe, rom_we, rom_oe, cpu_rdy} >> 1;
        n_cmp++;
        if ({ram_we, ram_oe, rom_we, rom_oe, cpu_rdy} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_outputs addr=%h: got %b expected 00000", addr, {ram_we, ram_oe, rom_we, rom_oe, cpu_rdy});
        end
        n_cmp++;
        if (cpu_rdata !== exp_rdata || wp_err !== exp_wp) begin
            n_err++;
            $display("FAIL idle_hold addr=%h: got rdata %h wp %b expected %h %b", addr, cpu_rdata, wp_err, exp_rdata, exp_wp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ram_we, ram_oe, rom_we, rom_oe, cpu_rdy, wp_err} !== 6'b0 || cpu_rdata !== 8'h00
            || mem_addr !== 15'h0 || mem_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got ctl %b rdata %h addr %h wdata %h expected all zero",
                     {ram_we, ram_oe, rom_we, rom_oe, cpu_rdy, wp_err}, cpu_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_write();
        int unsigned rc;
        run_txn(1'b1, 16'h0123, 8'hA5, 1'b0, rc);
        run_txn(1'b0, 16'h6123, 8'h00, 1'b0, rc);
    endtask

    task automatic test_rom_read();
        int unsigned rc;
        run_txn(1'b0, 16'hFFFC, 8'h00, 1'b0, rc);
    endtask

    task automatic test_back_to_back();
        int unsigned r1, r2;
        run_txn(1'b0, 16'h2005, 8'h00, 1'b1, r1);
        run_txn(1'b0, 16'h0005, 8'h00, 1'b1, r2);
        cpu_req = 1'b0;
        n_cmp++;
        if (r2 - r1 !== READ_LAT + 3) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d expected %0d", r2 - r1, READ_LAT + 3);
        end
    endtask

    task automatic test_write_protect();
        int unsigned rc;
        run_txn(1'b1, 16'h8000, 8'h3C, 1'b0, rc);
        run_txn(1'b0, 16'hA000, 8'h00, 1'b0, rc);
    endtask

    task automatic test_reset_mid_read();
        int unsigned rc;
        bit seen_rdy;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        exp_rdata = 8'h00; exp_wp = 1'b0;
        #1;
        n_cmp++;
        if ({ram_we, ram_oe, rom_we, rom_oe, cpu_rdy, wp_err} !== 6'b0 || cpu_rdata !== 8'h00
            || mem_addr !== 15'h0 || mem_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got ctl %b rdata %h addr %h wdata %h expected all zero",
                     {ram_we, ram_oe, rom_we, rom_oe, cpu_rdy, wp_err}, cpu_rdata, mem_addr, mem_wdata);
        end
        seen_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (cpu_rdy) seen_rdy = 1'b1;
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (cpu_rdy) seen_rdy = 1'b1;
        end
        n_cmp++;
        if (seen_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_rdy: got %b expected 0", seen_rdy);
        end
        run_txn(1'b0, 16'h0040, 8'h00, 1'b0, rc);
    endtask

    task automatic test_random();
        int unsigned rc;
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[12:4] = '0;
            run_txn(1'($urandom), a, 8'($urandom), 1'($urandom), rc);
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            exp_ram[i] = init_byte(13'(i), 1'b0);
            exp_rom[i] = init_byte(13'(i), 1'b1);
        end
        test_reset();
        test_ram_write();
        test_rom_read();
        test_back_to_back();
        test_write_protect();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 2, meaning memory read latency in clk cycles (legal range 1-7).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the number of low address bits decoded into each 8 KiB region.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: request valid level from the 6502 side.
REQ-006 SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read; sampled with cpu_req.
REQ-007 SHALL have port cpu_addr, input, 16 bits: CPU byte address.
REQ-008 SHALL have port cpu_wdata, input, 8 bits: write data from the CPU.
REQ-009 SHALL have port cpu_rdata, output, 8 bits: read data to the CPU.
REQ-010 SHALL have port cpu_rdy, output, 1 bit: transaction-complete pulse.
REQ-011 SHALL have port mem_addr, output, 15 bits: address to the memory stage.
REQ-012 SHALL have port mem_wdata, output, 8 bits: write data to the memory stage.
REQ-013 SHALL have port mem_rdata, input, 8 bits: read data from the memory stage.
REQ-014 SHALL have ports ram_we, ram_oe, rom_we, rom_oe, outputs, 1 bit each: per-region write/output enables.
REQ-015 SHALL have port wp_err, output, 1 bit: sticky ROM write-protect violation flag.

Function
REQ-016 SHALL decode cpu_addr[15] = 0 as RAM and cpu_addr[15] = 1 as ROM; mem_addr SHALL be {2'b00, cpu_addr[ADDR_W-1:0]}, so each region mirrors every 8 KiB.
REQ-017 SHALL implement the states IDLE, WRITE, READ and DONE.
REQ-018 In IDLE, cpu_req = 1 at a rising edge SHALL latch the address, cpu_we and cpu_wdata, then move to WRITE (cpu_we = 1) or READ (cpu_we = 0).
REQ-019 cpu_req SHALL be ignored in WRITE, READ and DONE; latched values SHALL stay constant until the state machine returns to IDLE.
REQ-020 WRITE SHALL last exactly 1 cycle with the selected region's we = 1 and mem_wdata valid, then move to DONE.
REQ-021 READ SHALL last READ_LAT+1 cycles with the selected region's oe = 1; mem_rdata SHALL be captured into cpu_rdata on the final READ edge, then move to DONE.
REQ-022 DONE SHALL last 1 cycle with cpu_rdy = 1, then return to IDLE.
REQ-023 cpu_rdata SHALL hold its value until the next read capture.
REQ-024 Write latency SHALL be: request sampled at edge 0, cpu_rdy high in cycle 2.
REQ-025 Read latency SHALL be: request sampled at edge 0, cpu_rdy high in cycle READ_LAT+2.
REQ-026 cpu_req still high in the cycle after DONE (IDLE) SHALL start a new transaction; back-to-back operation is legal.
REQ-027 At most one of ram_we, ram_oe, rom_we, rom_oe SHALL be high in any cycle; all four SHALL be 0 in IDLE and DONE.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, all enables 0, cpu_rdy 0, cpu_rdata 8'h00, mem_addr 0, mem_wdata 0 and wp_err 0, independent of clk.
REQ-029 Reset asserted mid-transaction SHALL abort it with no cpu_rdy pulse; the first request after release SHALL be handled normally.

Configuration
REQ-030 With macro MEMCTL_ROM_WP_EN defined, a write to the ROM region SHALL keep rom_we = 0 for the whole transaction, still complete with cpu_rdy per REQ-024, and set wp_err to 1 until reset.
REQ-031 Without MEMCTL_ROM_WP_EN, ROM writes SHALL assert rom_we like RAM writes, and wp_err SHALL be constant 0.

Verification
REQ-032 RAM write: req, we = 1, addr 16'h0123, wdata 8'hA5 -> ram_we high in cycle 1 only, mem_addr 15'h0123, cpu_rdy in cycle 2.
REQ-033 ROM read, READ_LAT = 2: addr 16'hFFFC, memory model returns 8'h00 -> rom_oe high in cycles 1-3, cpu_rdata 8'h00 and cpu_rdy in cycle 4.
REQ-034 Mirror and back-to-back: read 16'h2005 then 16'h0005 with req held high -> both mem_addr 15'h0005, two cpu_rdy pulses 5 cycles apart, enables one-hot or zero throughout.
REQ-035 Reset mid-read: reset_n low in cycle 2 of a READ -> all outputs 0 asynchronously, no cpu_rdy; next RAM read completes in READ_LAT+2 cycles.
REQ-036 Write protect: ROM write to 16'h8000 -> with MEMCTL_ROM_WP_EN, rom_we stays 0, wp_err = 1, cpu_rdy in cycle 2; without the macro, rom_we pulses and wp_err stays 0.
